if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, fetch-to-decode bundle, trap hold.
// Optional IF_STAGE_MISALIGN_CHECK_EN: raise instruction-address-misaligned on fetch of a PC with [1:0]!=0.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] pc_addr,
    input  logic [31:0] instruction,
    input  logic        imem_exc_en,
    input  logic [3:0]  imem_exc_code,
    input  logic [63:0] imem_exc_val,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_exc_en,
    output logic [3:0]  id_exc_code,
    output logic [63:0] id_exc_val
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FETCH     = 1'b0,
        TRAP_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic        w_slot_free;
    logic        w_misalign;

    assign pc_addr     = r_pc;
    assign w_slot_free = !id_valid || id_ready;

`ifdef IF_STAGE_MISALIGN_CHECK_EN
    assign w_misalign = (r_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_state     <= FETCH;
            id_valid    <= 1'b0;
            id_pc       <= 64'h0;
            id_instr    <= NOP_INSTR;
            id_exc_en   <= 1'b0;
            id_exc_code <= 4'h0;
            id_exc_val  <= 64'h0;
        end else if (redirect_en) begin
            r_pc     <= redirect_pc;
            id_valid <= 1'b0;
            r_state  <= FETCH;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_slot_free) begin
                        id_valid <= 1'b1;
                        id_pc    <= r_pc;
                        if (w_misalign) begin
                            // Misalignment outranks whatever memory returned for this address.
                            id_instr    <= NOP_INSTR;
                            id_exc_en   <= 1'b1;
                            id_exc_code <= 4'h0;
                            id_exc_val  <= r_pc;
                            r_state     <= TRAP_WAIT;
                        end else if (imem_exc_en) begin
                            id_instr    <= NOP_INSTR;
                            id_exc_en   <= 1'b1;
                            id_exc_code <= imem_exc_code;
                            id_exc_val  <= imem_exc_val;
                            r_state     <= TRAP_WAIT;
                        end else begin
                            id_instr    <= instruction;
                            id_exc_en   <= 1'b0;
                            id_exc_code <= imem_exc_code;
                            id_exc_val  <= imem_exc_val;
                            r_pc        <= r_pc + 64'd4;
                        end
                    end
                end
                TRAP_WAIT: begin
                    // Hold the faulting bundle until decode takes it, then idle until redirected.
                    if (id_valid && id_ready) begin
                        id_valid <= 1'b0;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

endmodule
